// File: rtl/adc_frame_averager.sv
// adc_frame_averager: periodic ADC conversion trigger plus 2^n-sample frame averager
// with a valid/ready result port. Define ADC_AVG_MINMAX_EN to build per-frame min/max.
module adc_frame_averager #(
    parameter int unsigned CLOCK_PERIOD     = 10,
    parameter int unsigned SAMPLE_PERIOD_NS = 6000,
    parameter int unsigned MAX_LOG2_AVG     = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [3:0]  avg_log2,
    output logic        adc_trigger,
    input  logic [15:0] adc_data,
    input  logic        adc_data_ready,
    output logic [15:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [15:0] m_tmin,
    output logic [15:0] m_tmax,
    output logic        overrun,
    output logic        busy
);
    localparam int unsigned TRIG_CYCLES = (SAMPLE_PERIOD_NS + CLOCK_PERIOD - 1) / CLOCK_PERIOD;
    localparam int unsigned PER_W       = $clog2(TRIG_CYCLES);
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ACC_W       = DATA_W + MAX_LOG2_AVG;
    localparam int unsigned CNT_W       = MAX_LOG2_AVG + 1;
    localparam int unsigned N_W         = 4;

    // Triggers closer than one full capture transaction would collide with the ADC.
    if (TRIG_CYCLES < 530) begin : g_trig_check
        $fatal(1, "adc_frame_averager: TRIG_CYCLES=%0d is below 530", TRIG_CYCLES);
    end

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e              state_q, state_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]    smp_cnt_q, smp_cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [N_W-1:0]      n_q, n_d;
    logic                trig_q, trig_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                overrun_q, overrun_d;

    logic [N_W-1:0]      n_clamp;
    logic [CNT_W-1:0]    frame_len_m1;
    logic                per_last;
    logic                frame_last;
    logic                frame_done;
    logic [ACC_W-1:0]    acc_sum;
    logic [DATA_W-1:0]   mean_c;

    assign n_clamp      = (avg_log2 > N_W'(MAX_LOG2_AVG)) ? N_W'(MAX_LOG2_AVG) : avg_log2;
    assign frame_len_m1 = (CNT_W'(1) << n_q) - CNT_W'(1);
    assign per_last     = (per_cnt_q == PER_W'(TRIG_CYCLES - 1));
    assign frame_last   = (smp_cnt_q == frame_len_m1);
    assign frame_done   = (state_q == S_RUN) && adc_data_ready && frame_last;
    assign acc_sum      = acc_q + ACC_W'(adc_data);
    assign mean_c       = DATA_W'(acc_sum >> n_q);

`ifdef ADC_AVG_MINMAX_EN
    logic [DATA_W-1:0]   run_min_q, run_min_d;
    logic [DATA_W-1:0]   run_max_q, run_max_d;
    logic [DATA_W-1:0]   tmin_q, tmin_d;
    logic [DATA_W-1:0]   tmax_q, tmax_d;
    logic                frame_first;
    logic [DATA_W-1:0]   frame_min;
    logic [DATA_W-1:0]   frame_max;

    // The first sample of a frame seeds both extremes, so stale running values never leak.
    assign frame_first = (smp_cnt_q == '0);
    assign frame_min   = (frame_first || (adc_data < run_min_q)) ? adc_data : run_min_q;
    assign frame_max   = (frame_first || (adc_data > run_max_q)) ? adc_data : run_max_q;
`endif

    // Next-state, counters, accumulator and output-register update.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        smp_cnt_d = smp_cnt_q;
        acc_d     = acc_q;
        n_d       = n_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        overrun_d = overrun_q;
        trig_d    = 1'b0;
        busy_d    = 1'b0;
`ifdef ADC_AVG_MINMAX_EN
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        tmin_d    = tmin_q;
        tmax_d    = tmax_q;
`endif

        case (state_q)
            S_IDLE: begin
                per_cnt_d = '0;
                smp_cnt_d = '0;
                acc_d     = '0;
                if (enable) begin
                    state_d   = S_RUN;
                    n_d       = n_clamp;
                    overrun_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d   = S_IDLE;
                    per_cnt_d = '0;
                    smp_cnt_d = '0;
                    acc_d     = '0;
                end else begin
                    per_cnt_d = per_last ? '0 : per_cnt_q + PER_W'(1);
                    if (adc_data_ready) begin
                        acc_d     = frame_last ? '0 : acc_sum;
                        smp_cnt_d = frame_last ? '0 : smp_cnt_q + CNT_W'(1);
`ifdef ADC_AVG_MINMAX_EN
                        run_min_d = frame_min;
                        run_max_d = frame_max;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        trig_d = (state_d == S_RUN) && (per_cnt_d == '0);
        busy_d = (state_d == S_RUN);

        // A held, unaccepted word wins over a new result; the new one is dropped.
        if (frame_done) begin
            if (!tvalid_q || m_tready) begin
                tdata_d  = mean_c;
                tvalid_d = 1'b1;
`ifdef ADC_AVG_MINMAX_EN
                tmin_d   = frame_min;
                tmax_d   = frame_max;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            per_cnt_q <= '0;
            smp_cnt_q <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef ADC_AVG_MINMAX_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_min_q <= '0;
            run_max_q <= '0;
            tmin_q    <= '0;
            tmax_q    <= '0;
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            tmin_q    <= tmin_d;
            tmax_q    <= tmax_d;
        end
    end

    assign m_tmin = tmin_q;
    assign m_tmax = tmax_q;
`else
    assign m_tmin = '0;
    assign m_tmax = '0;
`endif

    assign adc_trigger = trig_q;
    assign busy        = busy_q;
    assign m_tdata     = tdata_q;
    assign m_tvalid    = tvalid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_frame_averager.sv
// Scoreboard bench for adc_frame_averager: directed scenarios plus randomized frames
// checked against a frame-level averaging model.
module tb_adc_frame_averager;
    localparam int unsigned TRIG = 600;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [3:0]  avg_log2;
    logic        adc_trigger;
    logic [15:0] adc_data;
    logic        adc_data_ready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [15:0] m_tmin;
    logic [15:0] m_tmax;
    logic        overrun;
    logic        busy;

    adc_frame_averager #(
        .CLOCK_PERIOD    (10),
        .SAMPLE_PERIOD_NS(6000),
        .MAX_LOG2_AVG    (8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .avg_log2      (avg_log2),
        .adc_trigger   (adc_trigger),
        .adc_data      (adc_data),
        .adc_data_ready(adc_data_ready),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tmin        (m_tmin),
        .m_tmax        (m_tmax),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] mn;
        logic [15:0] mx;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned part_q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned mdl_n = 0;
    bit          mdl_run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame-level reference: collect 2^n samples, then mean by integer division.
    task automatic model_sample(input int unsigned d, input bit drop);
        int unsigned sum, mn, mx, len;
        exp_t e;
        if (!mdl_run) return;
        part_q.push_back(d);
        len = 1 << mdl_n;
        if (part_q.size() == len) begin
            sum = 0;
            mn  = part_q[0];
            mx  = part_q[0];
            foreach (part_q[i]) begin
                sum += part_q[i];
                if (part_q[i] < mn) mn = part_q[i];
                if (part_q[i] > mx) mx = part_q[i];
            end
            e.d = 16'(sum / len);
`ifdef ADC_AVG_MINMAX_EN
            e.mn = 16'(mn);
            e.mx = 16'(mx);
`else
            e.mn = 16'd0;
            e.mx = 16'd0;
`endif
            if (!drop) sb_q.push_back(e);
            part_q.delete();
        end
    endtask

    task automatic set_enable(input bit en);
        enable = en;
        mdl_run = en;
        part_q.delete();
        if (en) mdl_n = (avg_log2 > 4'd8) ? 8 : int'(avg_log2);
        tick(1);
    endtask

    task automatic pulse(input logic [15:0] d, input int gap, input bit drop);
        adc_data       = d;
        adc_data_ready = 1'b1;
        model_sample(int'(d), drop);
        tick(1);
        adc_data_ready = 1'b0;
        tick(gap);
    endtask

    // Final sample of a frame: no result before its pulse, result exactly one cycle after.
    task automatic pulse_last(input logic [15:0] d, input logic [15:0] exp_mean);
        adc_data       = d;
        adc_data_ready = 1'b1;
        model_sample(int'(d), 1'b0);
        @(negedge clk);
        chk("tvalid_before_last", m_tvalid, 0);
        @(posedge clk);
        #1;
        adc_data_ready = 1'b0;
        @(negedge clk);
        chk("tvalid_after_last", m_tvalid, 1);
        chk("tdata_after_last", m_tdata, exp_mean);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trigger(output int unsigned at);
        at = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (adc_trigger) begin
                at = cyc;
                break;
            end
        end
        if (at == 0) chk("trigger_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (adc_trigger) chk("trigger_only_when_busy", busy, 1);
            if (resetn && m_tvalid && m_tready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", m_tdata);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_mean", m_tdata, e.d);
                    chk("sb_min", m_tmin, e.mn);
                    chk("sb_max", m_tmax, e.mx);
                end
            end
        end
    endtask

    initial begin
        int unsigned t_prev, t_now, trig_cnt, nf, len, partial;
        logic [15:0] samp [4];

        resetn = 1'b0;
        enable = 1'b0;
        avg_log2 = 4'd0;
        adc_data = 16'd0;
        adc_data_ready = 1'b0;
        m_tready = 1'b1;
        fork
            monitor();
        join_none

        // Reset state and quiet idle
        tick(3);
        resetn = 1'b1;
        tick(1);
        @(negedge clk);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tmin", m_tmin, 0);
        chk("rst_tmax", m_tmax, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trigger", adc_trigger, 0);
        trig_cnt = 0;
        repeat (10000) begin
            @(negedge clk);
            if (adc_trigger) trig_cnt++;
        end
        chk("idle_triggers", trig_cnt, 0);
        @(posedge clk);
        #1;

        // Mean, trigger timing and result latency
        samp = '{16'd100, 16'd200, 16'd300, 16'd401};
        avg_log2 = 4'd2;
        enable = 1'b1;
        mdl_run = 1'b1;
        mdl_n = 2;
        part_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_enable", busy, 1);
        chk("first_trigger", adc_trigger, 1);
        t_prev = cyc;
        @(negedge clk);
        chk("trigger_one_cycle", adc_trigger, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_trigger(t_now);
                chk("trigger_spacing", t_now - t_prev, TRIG);
                t_prev = t_now;
            end
            tick(20 + $urandom_range(0, 300));
            if (i == 3) pulse_last(samp[i], 16'd250);
            else pulse(samp[i], 0, 1'b0);
        end
`ifdef ADC_AVG_MINMAX_EN
        @(negedge clk);
        chk("mean_min", m_tmin, 100);
        chk("mean_max", m_tmax, 401);
        @(posedge clk);
        #1;
`endif
        set_enable(1'b0);

        // Extremes: pass-through and clamped 256-sample frame
        avg_log2 = 4'd0;
        set_enable(1'b1);
        pulse(16'hFFFF, 2, 1'b0);
        set_enable(1'b0);
        avg_log2 = 4'd12;
        set_enable(1'b1);
        avg_log2 = 4'd0;
        for (int i = 0; i < 255; i++) pulse(16'hFFFF, 1, 1'b0);
        pulse_last(16'hFFFF, 16'hFFFF);
        tick(2);
        set_enable(1'b0);

        // Backpressure: dropped result and simultaneous accept/load
        avg_log2 = 4'd0;
        set_enable(1'b1);
        m_tready = 1'b0;
        pulse(16'd5, 1, 1'b0);
        pulse(16'd7, 1, 1'b1);
        @(negedge clk);
        chk("bp_hold_data", m_tdata, 5);
        chk("bp_hold_valid", m_tvalid, 1);
        chk("bp_overrun", overrun, 1);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        tick(2);
        set_enable(1'b0);
        set_enable(1'b1);
        chk("overrun_cleared", overrun, 0);
        m_tready = 1'b0;
        pulse(16'd9, 1, 1'b0);
        m_tready = 1'b1;
        pulse(16'd7, 2, 1'b0);
        chk("bp_same_cycle_overrun", overrun, 0);
        set_enable(1'b0);

        // Abort mid-frame, late sample in idle, then a clean frame
        avg_log2 = 4'd2;
        set_enable(1'b1);
        for (int i = 0; i < 3; i++) pulse(16'd1000, 3, 1'b0);
        set_enable(1'b0);
        pulse(16'd1000, 2, 1'b0);
        set_enable(1'b1);
        for (int i = 0; i < 4; i++) pulse(16'd4, 2, 1'b0);
        tick(2);
        chk("abort_overrun", overrun, 0);
        set_enable(1'b0);

        // Randomized episodes
        for (int ep = 0; ep < 25; ep++) begin
            avg_log2 = 4'($urandom_range(0, 6));
            set_enable(1'b1);
            avg_log2 = 4'($urandom_range(0, 15));
            len = 1 << mdl_n;
            nf = $urandom_range(1, 3);
            for (int f = 0; f < int'(nf); f++) begin
                for (int s = 0; s < int'(len); s++) begin
                    if (ep % 3 == 0) pulse(16'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0);
                    else pulse(16'($urandom), $urandom_range(0, 3), 1'b0);
                end
                tick($urandom_range(0, 2));
            end
            partial = $urandom_range(0, len - 1);
            for (int s = 0; s < int'(partial); s++) pulse(16'($urandom), 1, 1'b0);
            tick(2);
            set_enable(1'b0);
            tick($urandom_range(0, 5));
        end
        chk("random_overrun", overrun, 0);

        // Asynchronous reset with a held result and a partial frame
        avg_log2 = 4'd1;
        set_enable(1'b1);
        m_tready = 1'b0;
        pulse(16'd10, 1, 1'b1);
        pulse(16'd20, 1, 1'b1);
        pulse(16'd30, 1, 1'b1);
        chk("pre_reset_valid", m_tvalid, 1);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("areset_tvalid", m_tvalid, 0);
        chk("areset_tdata", m_tdata, 0);
        chk("areset_busy", busy, 0);
        chk("areset_trigger", adc_trigger, 0);
        chk("areset_overrun", overrun, 0);
        enable = 1'b0;
        mdl_run = 1'b0;
        part_q.delete();
        tick(2);
        resetn = 1'b1;
        m_tready = 1'b1;
        tick(2);
        chk("post_reset_valid", m_tvalid, 0);
        avg_log2 = 4'd0;
        set_enable(1'b1);
        pulse(16'h0055, 3, 1'b0);
        set_enable(1'b0);

        tick(3);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
